instr_fetch_buffer: RTL and testbench



---
 rtl/ifb_pkg.sv | 22 ++
 rtl/ifb_line_store.sv | 51 +++++
 rtl/instr_fetch_buffer.sv | 188 ++++++++++++++++++
 tb/tb_instr_fetch_buffer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifb_pkg.sv
// Shared definitions for the instruction fetch buffer: default parameters,
// controller state encoding and a saturating counter helper.
package ifb_pkg;

  localparam int unsigned IFB_ADDR_W  = 64;
  localparam int unsigned IFB_DATA_W  = 64;
  localparam int unsigned IFB_DEPTH   = 8;
  localparam int unsigned IFB_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } ifb_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ifb_line_store.sv
// Direct-mapped entry storage: per-entry valid bit, tag and data word.
// Combinational read at one index, single write port, whole-array flush.
module ifb_line_store
  import ifb_pkg::*;
#(
  parameter int unsigned DEPTH  = IFB_DEPTH,
  parameter int unsigned IDX_W  = $clog2(DEPTH),
  parameter int unsigned TAG_W  = 8,
  parameter int unsigned DATA_W = IFB_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic              rd_valid_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [DATA_W-1:0] wr_data_i
);

  logic [DEPTH-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  // Valid bits: cleared by reset or flush; flush wins over a same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data payload; meaningless until the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch buffer: direct-mapped lookup with single-cycle hits,
// miss handling over a request/grant/response memory port, a response
// timeout and saturating hit/miss statistics.
module instr_fetch_buffer
  import ifb_pkg::*;
#(
  parameter int unsigned ADDR_W  = IFB_ADDR_W,
  parameter int unsigned DATA_W  = IFB_DATA_W,
  parameter int unsigned DEPTH   = IFB_DEPTH,
  parameter int unsigned TIMEOUT = IFB_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic              flush,
  output logic              core_busy,
  output logic              core_instr_valid,
  output logic [DATA_W-1:0] core_instr,
  output logic              core_exc,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_gnt,
  input  logic              mem_rd_valid,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              mem_rd_err,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int unsigned B     = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(B);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned TAG_W = ADDR_W - OFF_W - IDX_W;
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  ifb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              nofill_q, nofill_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              ivalid_q, ivalid_d;
  logic              exc_q, exc_d;
  logic [31:0]       hit_q, hit_d;
  logic [31:0]       miss_q, miss_d;

  logic [OFF_W-1:0]  req_off;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [DATA_W-1:0] rd_data;
  logic              lookup_hit;
  logic              fill_en;

  assign req_off = core_addr[OFF_W-1:0];
  assign req_idx = core_addr[OFF_W +: IDX_W];
  assign req_tag = core_addr[ADDR_W-1 -: TAG_W];

  ifb_line_store #(
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) u_store (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush),
    .rd_idx_i   (req_idx),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .wr_en_i    (fill_en),
    .wr_idx_i   (addr_q[OFF_W +: IDX_W]),
    .wr_tag_i   (addr_q[ADDR_W-1 -: TAG_W]),
    .wr_data_i  (mem_rd_data)
  );

  // A flush in the lookup cycle makes the lookup miss.
  assign lookup_hit = rd_valid && (rd_tag == req_tag) && !flush;

  // Controller state and all registered core-facing results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      tmo_q    <= '0;
      nofill_q <= 1'b0;
      instr_q  <= '0;
      ivalid_q <= 1'b0;
      exc_q    <= 1'b0;
      hit_q    <= '0;
      miss_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      tmo_q    <= tmo_d;
      nofill_q <= nofill_d;
      instr_q  <= instr_d;
      ivalid_q <= ivalid_d;
      exc_q    <= exc_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  end

  // Next-state logic: lookup in IDLE, then request, wait, respond.
  // Response pulses default to zero so core_instr is zero whenever not valid.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    tmo_d    = tmo_q;
    nofill_d = nofill_q;
    instr_d  = '0;
    ivalid_d = 1'b0;
    exc_d    = 1'b0;
    hit_d    = hit_q;
    miss_d   = miss_q;
    fill_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (core_req) begin
          if (req_off != '0) begin
            exc_d = 1'b1;
          end else if (lookup_hit) begin
            ivalid_d = 1'b1;
            instr_d  = rd_data;
            hit_d    = sat_inc32(hit_q);
          end else begin
            addr_d   = core_addr;
            miss_d   = sat_inc32(miss_q);
            tmo_d    = '0;
            nofill_d = 1'b0;
            state_d  = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (flush) nofill_d = 1'b1;
        if (tmo_q == TMO_LAST) begin
          exc_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (mem_rd_gnt) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (flush) nofill_d = 1'b1;
        if (mem_rd_valid) begin
          if (mem_rd_err) begin
            exc_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            // A flush seen at any point since the miss suppresses the fill
            // but the data still goes back to the core.
            fill_en  = !nofill_q && !flush;
            instr_d  = mem_rd_data;
            ivalid_d = 1'b1;
            state_d  = ST_RESP;
          end
        end else if (tmo_q == TMO_LAST) begin
          exc_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign core_busy        = (state_q != ST_IDLE);
  assign core_instr_valid = ivalid_q;
  assign core_instr       = instr_q;
  assign core_exc         = exc_q;
  assign mem_rd_req       = (state_q == ST_REQ);
  assign mem_rd_addr      = mem_rd_req ? addr_q : '0;
  assign hit_cnt          = hit_q;
  assign miss_cnt         = miss_q;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Scoreboard bench for instr_fetch_buffer: stimulus pushes expected core
// responses (with the cycle they must appear in) and expected memory request
// addresses; monitors on the falling edge pop and compare.
module tb_instr_fetch_buffer;

  logic        clk;
  logic        rst_n;
  logic        core_req;
  logic [63:0] core_addr;
  logic        flush;
  logic        core_busy;
  logic        core_instr_valid;
  logic [63:0] core_instr;
  logic        core_exc;
  logic        mem_rd_req;
  logic [63:0] mem_rd_addr;
  logic        mem_rd_gnt;
  logic        mem_rd_valid;
  logic [63:0] mem_rd_data;
  logic        mem_rd_err;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  instr_fetch_buffer #(
    .ADDR_W  (64),
    .DATA_W  (64),
    .DEPTH   (8),
    .TIMEOUT (16)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .core_req         (core_req),
    .core_addr        (core_addr),
    .flush            (flush),
    .core_busy        (core_busy),
    .core_instr_valid (core_instr_valid),
    .core_instr       (core_instr),
    .core_exc         (core_exc),
    .mem_rd_req       (mem_rd_req),
    .mem_rd_addr      (mem_rd_addr),
    .mem_rd_gnt       (mem_rd_gnt),
    .mem_rd_valid     (mem_rd_valid),
    .mem_rd_data      (mem_rd_data),
    .mem_rd_err       (mem_rd_err),
    .hit_cnt          (hit_cnt),
    .miss_cnt         (miss_cnt)
  );

  typedef struct {
    bit          is_exc;
    logic [63:0] data;
    int          cyc;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [63:0] exp_mem[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          req_cycles = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Core response monitor and per-cycle output invariants.
  always @(negedge clk) begin
    rsp_t e;
    if (mem_rd_req) req_cycles++;
    checks++;
    if ((core_instr_valid && core_exc) || (!core_instr_valid && core_instr != 64'd0) ||
        (!mem_rd_req && mem_rd_addr != 64'd0)) begin
      errors++;
      $display("FAIL invariant cyc %0d: valid=%0b exc=%0b instr=%0h req=%0b addr=%0h",
               cyc, core_instr_valid, core_exc, core_instr, mem_rd_req, mem_rd_addr);
    end
    if (core_instr_valid || core_exc) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp cyc %0d: valid=%0b exc=%0b instr=%0h expected none",
                 cyc, core_instr_valid, core_exc, core_instr);
      end else begin
        e = exp_q.pop_front();
        if (core_exc !== e.is_exc || core_instr !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL core_rsp: got exc=%0b instr=%0h cyc=%0d expected exc=%0b instr=%0h cyc=%0d",
                   core_exc, core_instr, cyc, e.is_exc, e.data, e.cyc);
        end
      end
    end
    if (mem_rd_req && mem_rd_gnt) begin
      checks++;
      if (exp_mem.size() == 0) begin
        errors++;
        $display("FAIL unexpected_mem_req: got addr %0h expected none", mem_rd_addr);
      end else if (mem_rd_addr !== exp_mem[0]) begin
        errors++;
        $display("FAIL mem_addr: got %0h expected %0h", mem_rd_addr, exp_mem[0]);
        void'(exp_mem.pop_front());
      end else begin
        void'(exp_mem.pop_front());
      end
    end
  end

  task automatic fetch(input logic [63:0] a, input bit fl);
    core_req  = 1'b1;
    core_addr = a;
    flush     = fl;
    tick();
    core_req  = 1'b0;
    core_addr = '0;
    flush     = 1'b0;
  endtask

  task automatic hit(input logic [63:0] a, input logic [63:0] d);
    fetch(a, 1'b0);
    exp_q.push_back('{1'b0, d, cyc});
  endtask

  // Miss served after g grant-wait and r response-wait cycles.
  task automatic miss(input logic [63:0] a, input int g, input int r, input logic [63:0] d,
                      input bit err, input bit fl_req, input bit fl_wait);
    int n;
    exp_mem.push_back(a);
    fetch(a, fl_req);
    n = cyc;
    exp_q.push_back('{err, err ? 64'd0 : d, n + g + r + 2});
    repeat (g) tick();
    mem_rd_gnt = 1'b1;
    tick();
    mem_rd_gnt = 1'b0;
    flush = fl_wait;
    repeat (r) begin
      tick();
      flush = 1'b0;
    end
    mem_rd_valid = 1'b1;
    mem_rd_data  = d;
    mem_rd_err   = err;
    tick();
    flush        = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    mem_rd_err   = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    rst_n = 1'b0;
    core_req = 1'b0;
    core_addr = '0;
    flush = 1'b0;
    mem_rd_gnt = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rd_data = '0;
    mem_rd_err = 1'b0;
    repeat (3) tick();
    chk("rst_busy", core_busy, 0);
    chk("rst_valid", core_instr_valid, 0);
    chk("rst_exc", core_exc, 0);
    chk("rst_memreq", mem_rd_req, 0);
    chk("rst_hit", hit_cnt, 0);
    chk("rst_miss", miss_cnt, 0);
    rst_n = 1'b1;
    tick();

    // Cold miss then hit.
    miss(64'h1000, 2, 3, 64'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    chk("cold_miss_cnt", miss_cnt, 1);
    chk("cold_hit_cnt", hit_cnt, 0);
    base = req_cycles;
    hit(64'h1000, 64'hDEADBEEF);
    tick();
    chk("hit_no_memreq", req_cycles - base, 0);
    chk("hit_cnt1", hit_cnt, 1);

    // Conflict on index 0 evicts 0x1000.
    miss(64'h1040, 0, 0, 64'h11111111, 1'b0, 1'b0, 1'b0);
    miss(64'h1000, 1, 1, 64'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    chk("conflict_miss_cnt", miss_cnt, 3);
    hit(64'h1000, 64'hDEADBEEF);
    tick();
    chk("conflict_hit_cnt", hit_cnt, 2);

    // Misaligned fetch.
    base = req_cycles;
    fetch(64'h1004, 1'b0);
    exp_q.push_back('{1'b1, 64'd0, cyc});
    chk("misalign_busy", core_busy, 0);
    tick();
    chk("misalign_no_memreq", req_cycles - base, 0);
    chk("misalign_miss_cnt", miss_cnt, 3);
    chk("misalign_hit_cnt", hit_cnt, 2);

    // Bus error then refetch misses.
    miss(64'h1008, 0, 1, 64'hBADBAD, 1'b1, 1'b0, 1'b0);
    miss(64'h1008, 0, 0, 64'h12345678, 1'b0, 1'b0, 1'b0);
    chk("err_miss_cnt", miss_cnt, 5);
    hit(64'h1008, 64'h12345678);
    tick();
    chk("err_hit_cnt", hit_cnt, 3);

    // Timeout with no grant; late response ignored.
    base = req_cycles;
    fetch(64'h1010, 1'b0);
    n = cyc;
    exp_q.push_back('{1'b1, 64'd0, n + 16});
    repeat (16) tick();
    chk("tmo_req_cycles", req_cycles - base, 16);
    chk("tmo_memreq_low", mem_rd_req, 0);
    chk("tmo_busy_low", core_busy, 0);
    mem_rd_valid = 1'b1;
    mem_rd_data  = 64'hBAD0;
    tick();
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    tick();
    miss(64'h1010, 0, 0, 64'h77, 1'b0, 1'b0, 1'b0);
    chk("tmo_miss_cnt", miss_cnt, 7);

    // Flush during WAIT: data returned, no fill; flush with req: miss.
    miss(64'h2000, 0, 2, 64'h55, 1'b0, 1'b0, 1'b1);
    miss(64'h2000, 1, 0, 64'h66, 1'b0, 1'b0, 1'b0);
    miss(64'h2000, 0, 0, 64'h67, 1'b0, 1'b1, 1'b0);
    chk("flush_miss_cnt", miss_cnt, 10);
    hit(64'h2000, 64'h67);
    tick();
    chk("flush_hit_cnt", hit_cnt, 4);

    // Reset mid-WAIT abandons the miss.
    exp_mem.push_back(64'h3000);
    fetch(64'h3000, 1'b0);
    mem_rd_gnt = 1'b1;
    tick();
    mem_rd_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst2_busy", core_busy, 0);
    chk("rst2_memreq", mem_rd_req, 0);
    chk("rst2_instr", core_instr, 0);
    chk("rst2_hit", hit_cnt, 0);
    chk("rst2_miss", miss_cnt, 0);
    tick();
    rst_n = 1'b1;
    miss(64'h3000, 1, 2, 64'h99, 1'b0, 1'b0, 1'b0);
    chk("rst2_after_miss", miss_cnt, 1);
    hit(64'h3000, 64'h99);
    tick();
    chk("rst2_after_hit", hit_cnt, 1);

    repeat (4) tick();
    chk("rsp_queue_empty", exp_q.size(), 0);
    chk("mem_queue_empty", exp_mem.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
